// File: rtl/sys_mem_pkg.sv
// Shared types and constants for the Sys* bus memory responder.
package sys_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sys_mem_state_t;

  localparam logic SYS_RW_READ  = 1'b1;
  localparam logic SYS_RW_WRITE = 1'b0;

endpackage

// File: rtl/sys_mem_array.sv
// Single-port synchronous RAM with a registered read port (read-before-write on the same address).
module sys_mem_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic [AW-1:0] Address,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  input  logic          Write
);

  logic [DW-1:0] mem_q [2**AW];

  // Storage write and registered read
  always_ff @(posedge Clk) begin
    if (Write) begin
      mem_q[Address] <= DataIn;
    end
    DataOut <= mem_q[Address];
  end

endmodule

// File: rtl/sys_mem_responder.sv
// Sys* bus memory responder: strobe -> WAIT_CYCLES wait states -> one DONE cycle.
// Optional completion pulse SysReady is built when SYS_MEM_READY_EN is defined.
module sys_mem_responder
  import sys_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WORD_OFFSET = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SysStrobe,
  input  logic [ADDR_W-1:0] SysAddress,
  input  logic              SysRW,
`ifdef SYS_MEM_READY_EN
  output logic              SysReady,
`endif
  inout  wire  [DATA_W-1:0] SysData
);

  sys_mem_state_t        state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  rw_q;
  logic                  oe_q;
  logic [DATA_W-1:0]     rdata_s;
  logic                  mem_we_s;
  logic                  addr_unused_s;
`ifdef SYS_MEM_READY_EN
  logic                  ready_q;
`endif

  // Bits outside the word index are intentionally ignored (aliasing)
  assign addr_unused_s = ^{SysAddress[ADDR_W-1:WORD_OFFSET+DEPTH_LOG2],
                           SysAddress[WORD_OFFSET-1:0]};

  // Transaction FSM with latched request and registered bus controls
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= SYS_RW_WRITE;
      oe_q    <= 1'b0;
`ifdef SYS_MEM_READY_EN
      ready_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (SysStrobe) begin
            idx_q   <= SysAddress[WORD_OFFSET +: DEPTH_LOG2];
            rw_q    <= SysRW;
            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            oe_q    <= (rw_q == SYS_RW_READ);
`ifdef SYS_MEM_READY_EN
            ready_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
`ifdef SYS_MEM_READY_EN
          ready_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
`ifdef SYS_MEM_READY_EN
          ready_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  // A reset coinciding with the end of DONE discards the pending write
  assign mem_we_s = (state_q == DONE) && (rw_q == SYS_RW_WRITE) && !Reset;

  sys_mem_array #(
    .AW(DEPTH_LOG2),
    .DW(DATA_W)
  ) u_array (
    .Clk     (Clk),
    .Address (idx_q),
    .DataIn  (SysData),
    .DataOut (rdata_s),
    .Write   (mem_we_s)
  );

  assign SysData = oe_q ? rdata_s : {DATA_W{1'bz}};

`ifdef SYS_MEM_READY_EN
  assign SysReady = ready_q;
`endif

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder with a read-data scoreboard.
module tb_sys_mem_responder;
  import sys_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] tb_drv = 32'd0;
  logic        tb_oe = 1'b0;
  wire  [31:0] sys_data;
  logic        s6 = 1'b0;
  wire  [31:0] d1;
  wire  [31:0] d15;
`ifdef SYS_MEM_READY_EN
  logic        rdy;
  logic        rdy1;
  logic        rdy15;
`endif

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  assign sys_data = tb_oe ? tb_drv : 32'hzzzz_zzzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_mem_responder dut (
    .Clk(clk), .Reset(reset), .SysStrobe(strobe), .SysAddress(addr), .SysRW(rw),
`ifdef SYS_MEM_READY_EN
    .SysReady(rdy),
`endif
    .SysData(sys_data)
  );

  sys_mem_responder #(.WAIT_CYCLES(1)) u1 (
    .Clk(clk), .Reset(reset), .SysStrobe(s6), .SysAddress(32'd0), .SysRW(1'b1),
`ifdef SYS_MEM_READY_EN
    .SysReady(rdy1),
`endif
    .SysData(d1)
  );

  sys_mem_responder #(.WAIT_CYCLES(15)) u15 (
    .Clk(clk), .Reset(reset), .SysStrobe(s6), .SysAddress(32'd0), .SysRW(1'b1),
`ifdef SYS_MEM_READY_EN
    .SysReady(rdy15),
`endif
    .SysData(d15)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every driven read DONE must match the oldest scoreboard entry in data and cycle
  always @(negedge clk) begin
    if (dut.oe_q) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rd_data", sys_data, mon_e.data);
        chk("rd_cycle", 32'(cyc), 32'(mon_e.cycle));
      end
    end
  end

  task automatic do_txn(input logic is_rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic chg, input logic [31:0] chg_a);
    strobe = 1'b1;
    addr   = a;
    rw     = is_rd;
    if (!is_rd) begin
      tb_drv = wd;
      tb_oe  = 1'b1;
    end else begin
      sb_q.push_back('{ed, cyc + 3});
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        strobe = 1'b0;
        if (chg) begin
          addr = chg_a;
          rw   = ~is_rd;
        end
      end
      if (k == 4) tb_oe = 1'b0;
      chk("oe_window", {31'd0, dut.oe_q}, 32'(is_rd && k == 3));
`ifdef SYS_MEM_READY_EN
      chk("ready_window", {31'd0, rdy}, 32'(k == 3));
`endif
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_oe", {31'd0, dut.oe_q}, 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
`ifdef SYS_MEM_READY_EN
    chk("rst_ready", {31'd0, rdy}, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Basic write then read back
    do_txn(1'b0, 32'h40, 32'h0000_00A5, 32'd0, 1'b0, 32'd0);
    do_txn(1'b1, 32'h40, 32'd0, 32'h0000_00A5, 1'b0, 32'd0);

    // Aliasing above the word index
    do_txn(1'b0, 32'h40, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0);
    do_txn(1'b1, 32'h40 + (32'd4 << 10), 32'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);

    // Strobes during WAIT and DONE are ignored
    do_txn(1'b0, 32'h100, 32'h1111_1111, 32'd0, 1'b0, 32'd0);
    do_txn(1'b0, 32'h200, 32'h2222_2222, 32'd0, 1'b0, 32'd0);
    strobe = 1'b1; addr = 32'h100; rw = 1'b1;
    sb_q.push_back('{32'h1111_1111, cyc + 3});
    tick();
    addr = 32'h200;
    chk("busy_state_c1", 32'(dut.state_q), 32'(WAIT));
    tick();
    strobe = 1'b0;
    tick();
    strobe = 1'b1;
    chk("busy_oe_c3", {31'd0, dut.oe_q}, 32'd1);
    tick();
    chk("busy_oe_c4", {31'd0, dut.oe_q}, 32'd0);
    chk("busy_state_c4", 32'(dut.state_q), 32'(IDLE));
    sb_q.push_back('{32'h2222_2222, cyc + 3});
    tick();
    strobe = 1'b0;
    tick();
    tick();
    chk("busy_oe_c7", {31'd0, dut.oe_q}, 32'd1);
    tick();

    // Address/RW changes after the strobe cycle have no effect
    do_txn(1'b0, 32'hC0, 32'hCCCC_0000, 32'd0, 1'b0, 32'd0);
    do_txn(1'b0, 32'h80, 32'h8080_8080, 32'd0, 1'b1, 32'hC0);
    do_txn(1'b1, 32'h80, 32'd0, 32'h8080_8080, 1'b0, 32'd0);
    do_txn(1'b1, 32'hC0, 32'd0, 32'hCCCC_0000, 1'b0, 32'd0);

    // Reset in the middle of a write aborts it
    do_txn(1'b0, 32'h10, 32'h5555_AAAA, 32'd0, 1'b0, 32'd0);
    strobe = 1'b1; addr = 32'h10; rw = 1'b0; tb_drv = 32'h0000_1234; tb_oe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("abort_oe", {31'd0, dut.oe_q}, 32'd0);
    tb_oe = 1'b0;
    tick();

    // Strobe coincident with reset is dropped
    reset = 1'b1; strobe = 1'b1; addr = 32'h10; rw = 1'b1;
    tick();
    reset = 1'b0; strobe = 1'b0;
    chk("rst_strobe_c1", 32'(dut.state_q), 32'(IDLE));
    tick();
    tick();
    tick();
    chk("rst_strobe_c4", 32'(dut.state_q), 32'(IDLE));
    do_txn(1'b1, 32'h10, 32'd0, 32'h5555_AAAA, 1'b0, 32'd0);

    // Latency of the 1- and 15-wait-state builds
    s6 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 1) s6 = 1'b0;
      chk("lat1_oe", {31'd0, u1.oe_q}, 32'(k == 2));
      chk("lat15_oe", {31'd0, u15.oe_q}, 32'(k == 16));
`ifdef SYS_MEM_READY_EN
      chk("lat1_ready", {31'd0, rdy1}, 32'(k == 2));
      chk("lat15_ready", {31'd0, rdy15}, 32'(k == 16));
`endif
    end

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
